// File: rtl/seq_mult_pkg.sv
// Shared state encoding and sizing helper for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Step counter must hold 0..width-1; never narrower than one bit.
  function automatic int cntWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_pp_step.sv
// One partial-product step: adds or subtracts the shifted multiplicand into the accumulator.
module seq_mult_pp_step
  import seq_mult_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic [PW-1:0] i_acc,
  input  logic [PW-1:0] i_addend,
  input  logic          i_addEn,
  input  logic          i_subtract,
  output logic [PW-1:0] o_result
);

  always_comb begin
    o_result = i_acc;
    if (i_addEn) begin
      o_result = i_subtract ? (i_acc - i_addend) : (i_acc + i_addend);
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier, signed or unsigned per operation.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave CALC once no multiplier bits remain.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t          r_state;
  logic [PW-1:0]   r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_signed;
  logic [PW-1:0]   r_product;

  logic            w_lastStep;
  logic            w_subtract;
  logic            w_exit;
  logic [PW-1:0]   w_accNext;
  logic [PW-1:0]   w_aLoad;

  assign w_lastStep = (r_cnt == LAST_STEP);
  // The MSB of a two's complement multiplier carries weight -2^(WIDTH-1).
  assign w_subtract = r_signed & w_lastStep;
  assign w_aLoad    = signed_mode ? {{WIDTH{data_a[WIDTH-1]}}, data_a}
                                  : {{WIDTH{1'b0}}, data_a};

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign w_exit = w_lastStep | (r_b[WIDTH-1:1] == '0);
`else
  assign w_exit = w_lastStep;
`endif

  seq_mult_pp_step #(
    .PW(PW)
  ) u_ppStep (
    .i_acc      (r_acc),
    .i_addend   (r_a),
    .i_addEn    (r_b[0]),
    .i_subtract (w_subtract),
    .o_result   (w_accNext)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= w_aLoad;
            r_b      <= data_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_signed <= signed_mode;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_accNext;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_exit) begin
            r_product <= w_accNext;
            r_state   <= S_DONE;
          end
        end
        // Stay here while start is held so one request yields one result.
        S_DONE: begin
          if (!start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_CALC);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param at WIDTH=8; expected latency follows SEQ_MULT_EARLY_TERM_EN.
module tb_seq_mult_param;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [W-1:0]  data_a = '0;
  logic [W-1:0]  data_b = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int            vectorCount = 0;
  int            missCount = 0;
  int            cycleCnt = 0;
  logic [PW-1:0] lastProd = '0;
  logic          prevDone = 1'b0;

  typedef struct {
    logic [PW-1:0] prod;
    int            lat;
    int            loadCycle;
  } expect_t;

  expect_t sbQ[$];
  expect_t monEntry;

  seq_mult_param #(
    .WIDTH(W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .signed_mode (signed_mode),
    .data_a      (data_a),
    .data_b      (data_b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  // Clocks from the load edge to the first cycle done is visible, including the load edge.
  function automatic int expLatency(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) h = i + 1;
    end
    return 1 + ((h < 1) ? 1 : h);
`else
    return W + 1;
`endif
  endfunction

  // Monitor: every rising done retires the oldest scoreboard entry.
  always @(negedge clock) begin
    if (reset_n && done && !prevDone) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected done", 32'(done), 32'd0);
      end else begin
        monEntry = sbQ.pop_front();
        checkOutput("product", 32'(product), 32'(monEntry.prod));
        checkOutput("latency", 32'(cycleCnt - monEntry.loadCycle), 32'(monEntry.lat));
      end
    end
    prevDone = done;
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                               input logic [PW-1:0] expProd, input int holdCycles);
    expect_t e;
    int      waitCnt;
    logic    seen;
    @(negedge clock);
    data_a      = a;
    data_b      = b;
    signed_mode = sgn;
    start       = 1'b1;
    e.prod      = expProd;
    e.lat       = expLatency(b);
    e.loadCycle = cycleCnt;
    sbQ.push_back(e);
    @(negedge clock);
    checkOutput("busy after load", 32'(busy), 32'd1);
    checkOutput("product held until result", 32'(product), 32'(lastProd));
    data_a      = ~a;
    data_b      = ~b;
    signed_mode = ~sgn;
    seen    = done;
    waitCnt = 0;
    while (!seen && waitCnt < 4 * W) begin
      @(negedge clock);
      waitCnt++;
      seen = done;
    end
    if (!seen) begin
      checkOutput("done timeout", 32'(done), 32'd1);
      if (sbQ.size() != 0) void'(sbQ.pop_front());
    end
    repeat (holdCycles) begin
      @(negedge clock);
      checkOutput("done held with start", 32'(done), 32'd1);
      checkOutput("busy low while held", 32'(busy), 32'd0);
      checkOutput("product while held", 32'(product), 32'(expProd));
    end
    start = 1'b0;
    @(negedge clock);
    checkOutput("done after release", 32'(done), 32'd0);
    checkOutput("product in idle", 32'(product), 32'(expProd));
    lastProd = expProd;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset product", 32'(product), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    applyStimulus(8'h80, 8'h80, 1'b1, 16'h4000, 0);
    applyStimulus(8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
    applyStimulus(8'h07, 8'hFF, 1'b1, 16'hFFF9, 3);
    applyStimulus(8'hC8, 8'h00, 1'b0, 16'h0000, 0);
    applyStimulus(8'h03, 8'h01, 1'b0, 16'h0003, 0);
    applyStimulus(8'h05, 8'hFF, 1'b1, 16'hFFFB, 0);
    applyStimulus(8'hFD, 8'h05, 1'b0, 16'h04F1, 0);
    applyStimulus(8'h7F, 8'h80, 1'b1, 16'hC080, 0);
    applyStimulus(8'hF0, 8'h0F, 1'b0, 16'h0E10, 0);

    // Abort an operation mid-CALC; nothing is queued for it.
    @(negedge clock);
    data_a      = 8'd12;
    data_b      = 8'd12;
    signed_mode = 1'b0;
    start       = 1'b1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid-calc reset done", 32'(done), 32'd0);
    checkOutput("mid-calc reset busy", 32'(busy), 32'd0);
    checkOutput("mid-calc reset product", 32'(product), 32'd0);
    start = 1'b0;
    @(negedge clock);
    reset_n  = 1'b1;
    lastProd = '0;

    applyStimulus(8'd12, 8'd12, 1'b0, 16'h0090, 0);

    repeat (3) @(negedge clock);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
